// File: rtl/rambus_pkg.sv
// Shared definitions for the two-requester RAM arbiter: default widths,
// FSM state encoding and requester identity.
package rambus_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    ID_HOST = 1'b0,
    ID_CORE = 1'b1
  } req_id_e;

  // grant bus is {core,host}
  function automatic logic [1:0] id_onehot(input req_id_e id);
    return (id == ID_CORE) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rambus_arb_pick.sv
// Two-way winner select. Round-robin with a last-grant register by default;
// with RAMBUS_ARB_HOST_PRIORITY_EN defined the host always wins and no pointer exists.
module rambus_arb_pick
  import rambus_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    h_req,
  input  logic    c_req,
  input  logic    take,
  output req_id_e win
);

`ifdef RAMBUS_ARB_HOST_PRIORITY_EN
  logic unused_pick;
  assign unused_pick = ^{clock, reset, take, c_req};

  always_comb begin
    win = h_req ? ID_HOST : ID_CORE;
  end
`else
  req_id_e last_q, last_d;

  always_comb begin
    win = h_req ? ID_HOST : ID_CORE;
    if (h_req && c_req) begin
      win = (last_q == ID_CORE) ? ID_HOST : ID_CORE;
    end
    last_d = take ? win : last_q;
  end

  // Core counts as last-granted out of reset so the host wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) last_q <= ID_CORE;
    else       last_q <= last_d;
  end
`endif

endmodule

// File: rtl/rambus_arbiter.sv
// Arbitrates a host and a core requester onto one RAM port; one access per 3 cycles.
// Tie-break is round-robin unless RAMBUS_ARB_HOST_PRIORITY_EN is defined (host priority).
module rambus_arbiter
  import rambus_pkg::*;
#(
  parameter  int ADDR_W = ADDR_W_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int SEL_W  = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              h_cyc,
  input  logic              h_stb,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_dat_i,
  input  logic [SEL_W-1:0]  h_sel,
  output logic              h_ack,
  output logic [DATA_W-1:0] h_dat_o,
  input  logic              c_cyc,
  input  logic              c_stb,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_dat_i,
  input  logic [SEL_W-1:0]  c_sel,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_dat_o,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [SEL_W-1:0]  ram_sel,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        grant,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  req_id_e           own_q, own_d;
  logic              we_q, we_d;
  logic [1:0]        grant_q, grant_d;
  logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [SEL_W-1:0]  ram_sel_q, ram_sel_d;
  logic              h_ack_q, h_ack_d, c_ack_q, c_ack_d;
  logic [DATA_W-1:0] h_dat_q, h_dat_d, c_dat_q, c_dat_d;

  logic    h_req, c_req, take;
  req_id_e win;

  assign h_req = h_cyc & h_stb;
  assign c_req = c_cyc & c_stb;

  rambus_arb_pick u_pick (
    .clock (clock),
    .reset (reset),
    .h_req (h_req),
    .c_req (c_req),
    .take  (take),
    .win   (win)
  );

  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    we_d        = we_q;
    grant_d     = grant_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    ram_sel_d   = '0;
    h_ack_d     = 1'b0;
    c_ack_d     = 1'b0;
    take        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (h_req || c_req) begin
          take        = 1'b1;
          own_d       = win;
          we_d        = (win == ID_CORE) ? c_we : h_we;
          grant_d     = id_onehot(win);
          ram_en_d    = 1'b1;
          ram_we_d    = we_d;
          ram_addr_d  = (win == ID_CORE) ? c_addr  : h_addr;
          ram_wdata_d = (win == ID_CORE) ? c_dat_i : h_dat_i;
          ram_sel_d   = (win == ID_CORE) ? c_sel   : h_sel;
          state_d     = ST_ACCESS;
        end
      end
      // The RAM cycle has already been issued; an owner that abandoned cyc gets no ack.
      ST_ACCESS: begin
        h_ack_d = (own_q == ID_HOST) && h_cyc;
        c_ack_d = (own_q == ID_CORE) && c_cyc;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read data arrives from the RAM's output register during the ack cycle and is held afterwards.
  assign h_dat_o = (h_ack_q && !we_q) ? ram_rdata : h_dat_q;
  assign c_dat_o = (c_ack_q && !we_q) ? ram_rdata : c_dat_q;
  assign h_dat_d = h_dat_o;
  assign c_dat_d = c_dat_o;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      own_q       <= ID_HOST;
      we_q        <= 1'b0;
      grant_q     <= 2'b00;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_sel_q   <= '0;
      h_ack_q     <= 1'b0;
      c_ack_q     <= 1'b0;
      h_dat_q     <= '0;
      c_dat_q     <= '0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      we_q        <= we_d;
      grant_q     <= grant_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_sel_q   <= ram_sel_d;
      h_ack_q     <= h_ack_d;
      c_ack_q     <= c_ack_d;
      h_dat_q     <= h_dat_d;
      c_dat_q     <= c_dat_d;
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_sel   = ram_sel_q;
  assign h_ack     = h_ack_q;
  assign c_ack     = c_ack_q;
  assign grant     = grant_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rambus_arbiter.sv
// Directed bench for rambus_arbiter with a byte-enabled RAM model behind the shared port.
module tb_rambus_arbiter;
  import rambus_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        h_cyc, h_stb, h_we, c_cyc, c_stb, c_we;
  logic [9:0]  h_addr, c_addr;
  logic [31:0] h_dat_i, c_dat_i;
  logic [3:0]  h_sel, c_sel;
  logic        h_ack, c_ack;
  logic [31:0] h_dat_o, c_dat_o;
  logic        ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;
  logic [1:0]  grant;
  state_e      dbg_state;

  int checks = 0;
  int errors = 0;

  rambus_arbiter dut (
    .clock(clock), .reset(reset),
    .h_cyc(h_cyc), .h_stb(h_stb), .h_we(h_we), .h_addr(h_addr), .h_dat_i(h_dat_i),
    .h_sel(h_sel), .h_ack(h_ack), .h_dat_o(h_dat_o),
    .c_cyc(c_cyc), .c_stb(c_stb), .c_we(c_we), .c_addr(c_addr), .c_dat_i(c_dat_i),
    .c_sel(c_sel), .c_ack(c_ack), .c_dat_o(c_dat_o),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_sel(ram_sel), .ram_rdata(ram_rdata), .grant(grant), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // RAM model: synchronous, byte-enabled write, read data valid the cycle after ram_en
  logic [31:0] mem [0:1023];
  logic [31:0] ram_merge;
  always_comb begin
    ram_merge = mem[ram_addr];
    for (int b = 0; b < 4; b++)
      if (ram_sel[b]) ram_merge[8*b +: 8] = ram_wdata[8*b +: 8];
  end
  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_merge;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic is_core, input logic we, input logic [9:0] addr,
                       input logic [31:0] data, input logic [3:0] sel);
    if (is_core) begin
      c_cyc = 1'b1; c_stb = 1'b1; c_we = we; c_addr = addr; c_dat_i = data; c_sel = sel;
    end else begin
      h_cyc = 1'b1; h_stb = 1'b1; h_we = we; h_addr = addr; h_dat_i = data; h_sel = sel;
    end
  endtask

  task automatic drop_all();
    h_cyc = 1'b0; h_stb = 1'b0; c_cyc = 1'b0; c_stb = 1'b0;
  endtask

  // One isolated access: request, check RAM cycle, check ack/read data, check return to idle.
  task automatic access(input logic is_core, input logic we, input logic [9:0] addr,
                        input logic [31:0] data, input logic [3:0] sel, input logic [31:0] exp_rd);
    drive(is_core, we, addr, data, sel);
    tick();
    check("acc_grant", grant, is_core ? 2'b10 : 2'b01);
    check("acc_ram_en", ram_en, 1'b1);
    check("acc_ram_we", ram_we, we);
    check("acc_ram_addr", ram_addr, addr);
    tick();
    check("acc_ram_en_off", ram_en, 1'b0);
    check("acc_h_ack", h_ack, !is_core);
    check("acc_c_ack", c_ack, is_core);
    if (!we) check("acc_rd_data", is_core ? c_dat_o : h_dat_o, exp_rd);
    drop_all();
    tick();
    check("acc_ack_clear", {c_ack, h_ack}, 2'b00);
    check("acc_grant_idle", grant, 2'b00);
  endtask

  initial begin
    int host_n, core_n;
    logic [1:0] exp_g;
    reset = 1'b1;
    drop_all();
    h_we = 0; h_addr = 0; h_dat_i = 0; h_sel = 0;
    c_we = 0; c_addr = 0; c_dat_i = 0; c_sel = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    ram_rdata = 32'h0;

    // reset state
    #3;
    check("rst_grant", grant, 2'b00);
    check("rst_acks", {c_ack, h_ack}, 2'b00);
    check("rst_ram_ctl", {ram_en, ram_we}, 2'b00);
    check("rst_ram_addr", ram_addr, 10'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_ram_sel", ram_sel, 4'h0);
    check("rst_dat_o", h_dat_o | c_dat_o, 32'h0);
    check("rst_state", dbg_state, ST_IDLE);
    tick(); tick();
    reset = 1'b0;
    tick();

    // host write then read back at fixed latency; core never acked
    drive(1'b0, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF);
    tick();
    check("hw_wdata", ram_wdata, 32'hDEADBEEF);
    check("hw_sel", ram_sel, 4'hF);
    check("hw_ack_early", h_ack, 1'b0);
    tick();
    check("hw_ack", h_ack, 1'b1);
    check("hw_c_ack", c_ack, 1'b0);
    check("hw_ram_zero", {ram_addr, ram_wdata}, 42'h0);
    drop_all();
    tick();
    check("hw_idle", dbg_state, ST_IDLE);
    access(1'b0, 1'b0, 10'h005, 32'h0, 4'hF, 32'hDEADBEEF);
    check("hr_hold", h_dat_o, 32'hDEADBEEF);
    check("hr_c_dat", c_dat_o, 32'h0);

    // owner drops cyc during ACCESS: write still commits, no ack
    drive(1'b0, 1'b1, 10'h007, 32'h000000AA, 4'hF);
    tick();
    check("drop_ram_en", ram_en, 1'b1);
    drop_all();
    tick();
    check("drop_no_ack", {c_ack, h_ack}, 2'b00);
    tick();
    access(1'b0, 1'b0, 10'h007, 32'h0, 4'hF, 32'h000000AA);

    // reset during ACCESS: ram_en falls immediately, access lost
    drive(1'b0, 1'b1, 10'h009, 32'h55555555, 4'hF);
    tick();
    check("rsta_ram_en", ram_en, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rsta_ram_en_async", ram_en, 1'b0);
    check("rsta_grant", grant, 2'b00);
    check("rsta_ram_addr", ram_addr, 10'h0);
    drop_all();
    tick();
    reset = 1'b0;
    tick();
    check("rsta_no_ack", {c_ack, h_ack}, 2'b00);
    check("rsta_state", dbg_state, ST_IDLE);
    access(1'b0, 1'b0, 10'h009, 32'h0, 4'hF, 32'h0);

    // simultaneous requests after reset: host first, core 3 cycles later
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    drive(1'b0, 1'b0, 10'h005, 32'h0, 4'hF);
    drive(1'b1, 1'b0, 10'h3FF, 32'h0, 4'hF);
    tick();
    check("tie_grant_host", grant, 2'b01);
    check("tie_addr_host", ram_addr, 10'h005);
    tick();
    check("tie_h_ack", {c_ack, h_ack}, 2'b01);
    check("tie_h_dat", h_dat_o, 32'hDEADBEEF);
    h_cyc = 1'b0; h_stb = 1'b0;
    tick();
    check("tie_gap", {grant, c_ack, h_ack}, 4'h0);
    tick();
    check("tie_grant_core", grant, 2'b10);
    check("tie_addr_core", ram_addr, 10'h3FF);
    tick();
    check("tie_c_ack", {c_ack, h_ack}, 2'b10);
    drop_all();
    tick();

    // core partial write over all-ones
    access(1'b1, 1'b1, 10'h3FF, 32'hFFFFFFFF, 4'hF, 32'h0);
    access(1'b1, 1'b1, 10'h3FF, 32'h12345678, 4'h3, 32'h0);
    access(1'b1, 1'b0, 10'h3FF, 32'h0, 4'hF, 32'hFFFF5678);

    // both requesting continuously; last grant was core so host leads
    drive(1'b0, 1'b0, 10'h005, 32'h0, 4'hF);
    drive(1'b1, 1'b0, 10'h3FF, 32'h0, 4'hF);
    host_n = 0;
    core_n = 0;
    for (int i = 0; i < 6; i++) begin
`ifdef RAMBUS_ARB_HOST_PRIORITY_EN
      exp_g = 2'b01;
`else
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      tick();
      check("cont_grant", grant, exp_g);
      check("cont_addr", ram_addr, (exp_g == 2'b01) ? 10'h005 : 10'h3FF);
      if (grant == 2'b01) host_n++;
      if (grant == 2'b10) core_n++;
      tick();
      check("cont_acks", {c_ack, h_ack}, exp_g);
      tick();
    end
    check("cont_host_count", host_n, 6 - core_n);
`ifdef RAMBUS_ARB_HOST_PRIORITY_EN
    check("cont_core_starved", core_n, 0);
`else
    check("cont_core_count", core_n, 3);
`endif
    drop_all();
    tick();
    check("end_idle", dbg_state, ST_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rambus_arbiter.md
RAMBUS_ARBITER -- requirements
Module: rambus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byte-select width SEL_W = DATA_W/8.
REQ-003 SHALL have port clock, in, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, in, 1, asynchronous active-high reset.
REQ-005 SHALL have ports h_cyc, h_stb and h_we, in, 1 each, host (Caravel Wishbone) request qualifiers.
REQ-006 SHALL have ports h_addr in ADDR_W, h_dat_i in DATA_W and h_sel in SEL_W, host address, write data and byte selects.
REQ-007 SHALL have ports h_ack out 1 and h_dat_o out DATA_W, host acknowledge and read data.
REQ-008 SHALL have ports c_cyc, c_stb, c_we, c_addr, c_dat_i, c_sel, c_ack and c_dat_o, spell-core requester, same widths/directions as host.
REQ-009 SHALL have ports ram_en, ram_we, ram_addr, ram_wdata and ram_sel, out, widths 1/1/ADDR_W/DATA_W/SEL_W, single shared RAM port.
REQ-010 SHALL have port ram_rdata, in, DATA_W, RAM read data, valid the cycle after ram_en.
REQ-011 SHALL have port grant, out, 2, one-hot owner of current access ({core,host}); 0 when idle.

Function
REQ-012 SHALL treat a requester as requesting when cyc&stb=1.
REQ-013 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-014 SHALL in IDLE with any request, latch the winner's addr/we/wdata/sel and id into registers and go to ACCESS; otherwise stay in IDLE.
REQ-015 SHALL in ACCESS drive ram_en=1 for exactly one cycle from latched values; ram_we=latched we.
REQ-016 SHALL in RESP assert winner's ack for exactly one cycle; on reads, dat_o = ram_rdata captured that cycle, else hold previous value.
REQ-017 SHALL give fixed latency: request sampled at edge N, ram_en high in cycle N+1, ack high in cycle N+2; back-to-back throughput one access per 3 cycles.
REQ-018 SHALL on simultaneous requests in IDLE grant the requester not granted last (round-robin); after reset last-granted = core, so host wins first tie.
REQ-019 SHALL, if the owner drops cyc during ACCESS or RESP, still complete the RAM cycle (writes commit) but suppress ack.
REQ-020 SHALL never assert ack to the non-owner and never assert both acks in one cycle.
REQ-021 SHALL keep all outputs registered; ram_* driven 0 whenever ram_en=0.

Reset
REQ-022 SHALL on reset force state IDLE, grant=0, h_ack=c_ack=0, ram_en=ram_we=0, ram_addr/ram_wdata/ram_sel=0, h_dat_o=c_dat_o=0, last-granted=core.
REQ-023 SHALL on reset asserted mid-access drop ram_en immediately (asynchronously); the interrupted access is lost, no ack issued.

Configuration
REQ-024 SHALL honour macro RAMBUS_ARB_HOST_PRIORITY_EN: defined -> host always wins ties, round-robin pointer absent; undefined -> REQ-018 round-robin.

Structure
REQ-025 SHALL place ADDR_W/DATA_W defaults, FSM state enum and requester-id typedef in shared package rambus_pkg.
REQ-026 SHALL factor tie-break logic into one sub-module rambus_arb_pick (2-way round-robin/priority select with last-grant register).

Verification
REQ-027 SHALL cover host write addr 0x005 data 0xDEADBEEF sel 0xF, then host read 0x005 -> h_ack at N+2 with h_dat_o=0xDEADBEEF, c_ack stays 0.
REQ-028 SHALL cover host and core requesting same cycle after reset -> host granted first (grant=01), core next (grant=10), acks 3 cycles apart.
REQ-029 SHALL cover core holding request continuously while host requests every cycle -> grants alternate core/host; neither starves.
REQ-030 SHALL cover core write 0x3FF sel 0x3 data 0x12345678 over 0xFFFFFFFF, then read -> 0xFFFF5678.
REQ-031 SHALL cover reset asserted during ACCESS -> ram_en falls same cycle, no ack, state IDLE after release.
REQ-032 SHALL cover build with RAMBUS_ARB_HOST_PRIORITY_EN, both requesting continuously -> host granted every time, core starved.
